// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input conditioner: the register map
// address type and the four register addresses.
package gpio_pkg;

  typedef logic [1:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_ADDR_VALUE   = 2'd0;  // debounced pin levels, read-only
  localparam gpio_addr_t GPIO_ADDR_RISE_EN = 2'd1;  // per-bit rising-edge event enable
  localparam gpio_addr_t GPIO_ADDR_FALL_EN = 2'd2;  // per-bit falling-edge event enable
  localparam gpio_addr_t GPIO_ADDR_STATUS  = 2'd3;  // sticky edge events, write-1-to-clear

endpackage

// File: rtl/gpio_in_filter.sv
// Single-pin conditioner: two-flop synchronizer followed by an optional
// debounce filter. Build option: GPIO_IN_DEBOUNCE_EN compiles in the
// debounce counter; without it the stable level simply follows sync2.
module gpio_in_filter #(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable
);

  logic sync1;
  logic sync2;

  // Bring the asynchronous pin into the clk domain before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DEBOUNCE_BITS-1:0] count;

  // Count consecutive cycles where the synchronized level disagrees with the
  // stable level; flip only after 2^DEBOUNCE_BITS such cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      count <= '0;
    end else if (count == {DEBOUNCE_BITS{1'b1}}) begin
      stable <= ~stable;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
`else
  // Filter length has no meaning without the counter.
  localparam int unused_debounce_bits = DEBOUNCE_BITS;

  // No filtering: the stable level is the synchronized level one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
    end else begin
      stable <= sync2;
    end
  end
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: WIDTH pins are synchronized and (optionally)
// debounced, edges on the stable levels raise sticky STATUS bits under
// RISE_EN/FALL_EN masks, and irq reflects any pending STATUS bit.
// Build option: GPIO_IN_DEBOUNCE_EN enables the per-pin debounce counters.
//
// Register port handshake: req_valid is a one-cycle strobe accepted every
// cycle with no backpressure; exactly one cycle later rsp_valid pulses with
// rsp_data holding the read value as of the request cycle (0 for writes).
// A request in a cycle where rst is high is discarded.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_pins,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [1:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_status;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_in_filter #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (input_pins[g]),
      .stable(stable[g])
    );
  end

  assign wr_rise   = req_valid && req_wr && (req_addr == GPIO_ADDR_RISE_EN);
  assign wr_fall   = req_valid && req_wr && (req_addr == GPIO_ADDR_FALL_EN);
  assign wr_status = req_valid && req_wr && (req_addr == GPIO_ADDR_STATUS);

  assign status_clr = wr_status ? req_wdata : '0;

  // Edges are seen one cycle after the stable level flips, against the
  // masks currently held (a mask write affects the following cycle onward).
  assign edge_ev = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);

  // Read mux over the register map, using pre-edge register contents.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      GPIO_ADDR_VALUE:   rd_data = stable;
      GPIO_ADDR_RISE_EN: rd_data = rise_en;
      GPIO_ADDR_FALL_EN: rd_data = fall_en;
      GPIO_ADDR_STATUS:  rd_data = status;
      default:           rd_data = '0;
    endcase
  end

  // Control/status registers; a new edge event overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      irq      <= 1'b0;
    end else begin
      stable_d <= stable;
      if (wr_rise) rise_en <= req_wdata;
      if (wr_fall) fall_en <= req_wdata;
      status <= (status & ~status_clr) | edge_ev;
      irq    <= |status;
    end
  end

  // Response one cycle after every accepted request; VALUE writes are just acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= req_valid;
      rsp_data  <= (req_valid && !req_wr) ? rd_data : '0;
    end
  end

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input pins conditioned.
REQ-002 SHALL have parameter DEBOUNCE_BITS, default 4, debounce counter width; filter length 2^DEBOUNCE_BITS cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port input_pins  input  WIDTH  raw asynchronous board pins.
REQ-006 SHALL have port req_valid  input  1  register access request, one-cycle strobe.
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  2  0 VALUE (RO), 1 RISE_EN (RW), 2 FALL_EN (RW), 3 STATUS (W1C).
REQ-009 SHALL have port req_wdata  input  WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  read/write completion strobe.
REQ-011 SHALL have port rsp_data  output  WIDTH  read data, valid with rsp_valid.
REQ-012 SHALL have port irq  output  1  level interrupt, high while any STATUS bit set.

Function
REQ-013 SHALL pass each input_pins bit through a two-flop synchronizer (sync1, sync2) before any use.
REQ-014 SHALL hold a per-bit stable value; VALUE register reads the stable vector.
REQ-015 With debounce: per-bit counter clears whenever sync2 == stable and increments while they differ; stable flips and counter clears on the edge where counter == 2^DEBOUNCE_BITS-1 and still differing.
REQ-016 A pin change sampled by sync1 at edge N SHALL appear in stable at edge N+1+2^DEBOUNCE_BITS (debounce on) or N+2 (debounce off).
REQ-017 A glitch shorter than 2^DEBOUNCE_BITS cycles in sync2 SHALL not change stable.
REQ-018 A stable 0->1 flip on bit i SHALL set STATUS[i] on the next edge if RISE_EN[i]; a 1->0 flip if FALL_EN[i].
REQ-019 A STATUS write SHALL clear bits where req_wdata is 1; an edge event on the same cycle as its clear SHALL win (bit stays set).
REQ-020 Writes to VALUE SHALL be ignored; still acknowledged.
REQ-021 Every request SHALL produce rsp_valid exactly one cycle later; req_valid is accepted every cycle (no backpressure).
REQ-022 rsp_data SHALL carry the register value as of the request cycle for reads, and 0 for writes.
REQ-023 Writes to RISE_EN/FALL_EN SHALL take effect for edges detected from the cycle after the write.
REQ-024 irq SHALL be registered: OR of STATUS, one cycle after STATUS changes.

Reset
REQ-025 rst SHALL clear sync1, sync2, stable, counters, RISE_EN, FALL_EN, STATUS; rsp_valid=0, rsp_data=0, irq=0.
REQ-026 A request coinciding with rst SHALL be dropped (no rsp_valid after reset).
REQ-027 After rst deasserts with a pin held high, stable SHALL rise per REQ-016 but, masks being 0, SHALL not set STATUS.

Configuration
REQ-028 Macro GPIO_IN_DEBOUNCE_EN defined: debounce counters per REQ-015 compiled in.
REQ-029 Macro GPIO_IN_DEBOUNCE_EN undefined: no counters; stable <= sync2 every cycle; DEBOUNCE_BITS ignored.

Structure
REQ-030 Shared package gpio_pkg SHALL hold the register address constants (GPIO_ADDR_VALUE/RISE_EN/FALL_EN/STATUS) and the 2-bit address typedef.
REQ-031 Per-bit sync+debounce SHALL be sub-module gpio_in_filter, instantiated WIDTH times via generate.

Verification
REQ-032 Debounce on, DB=4: input_pins[0] 0->1 sampled at edge 10 -> VALUE[0]=1 from edge 27; not earlier.
REQ-033 Debounce on: 10-cycle pulse on input_pins[3] -> VALUE stays 0x00, STATUS stays 0x00, irq stays 0.
REQ-034 RISE_EN=0x01, pin0 rises -> STATUS=0x01, irq=1; write STATUS 0x01 -> STATUS=0x00, irq=0 next cycle.
REQ-035 FALL_EN=0x80, pin7 falls and STATUS write 0x80 lands on event cycle -> STATUS[7] remains 1.
REQ-036 Read addr 1 after writing 0x5A -> rsp_valid one cycle later, rsp_data=0x5A; write addr 0 -> rsp_data=0x00, VALUE unchanged.
REQ-037 rst asserted mid-debounce (counter=9) -> all registers 0, counting restarts from 0 after release.
